// File: rtl/efuse_macro_seq_pkg.sv
// ============================================================================
// efuse_pkg -- shared constants and FSM encoding for the efuse macro sequencer
// Revision 1.0
// ============================================================================
`default_nettype none

package efuse_pkg;

  localparam int EFUSE_BITS = 256;
  localparam int EFUSE_DW   = 8;
  localparam int EFUSE_AW   = 8;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    RD_SU  = 4'd1,
    RD_STB = 4'd2,
    RD_HLD = 4'd3,
    WR_CHK = 4'd4,
    WR_SU  = 4'd5,
    WR_PGM = 4'd6,
    WR_HLD = 4'd7,
    DONE   = 4'd8
  } state_t;

endpackage

`default_nettype wire

// File: rtl/efuse_macro_seq_if.sv
// ============================================================================
// efuse_macro_seq_if -- request/response bundle between efuse_rw_ctrl and the sequencer
// Revision 1.0
// ============================================================================
`default_nettype none

interface efuse_macro_seq_if #(
  parameter int NR = 64,
  parameter int NW = 64
);

  localparam int RSW = $clog2(efuse_pkg::EFUSE_BITS / NR);
  localparam int WSW = $clog2(efuse_pkg::EFUSE_BITS / NW);

  logic           read_start;
  logic [RSW-1:0] read_sel;
  logic           read_done;
  logic [NR-1:0]  read_data;
  logic           efuse_busy_read;
  logic           write_start;
  logic [WSW-1:0] write_sel;
  logic [NW-1:0]  write_data;
  logic           write_done;
  logic           efuse_busy_write;

  modport master (
    output read_start, read_sel, write_start, write_sel, write_data,
    input  read_done, read_data, efuse_busy_read, write_done, efuse_busy_write
  );

  modport slave (
    input  read_start, read_sel, write_start, write_sel, write_data,
    output read_done, read_data, efuse_busy_read, write_done, efuse_busy_write
  );

endinterface

`default_nettype wire

// File: rtl/efuse_macro_seq_tcnt.sv
// ============================================================================
// efuse_tcnt -- loadable saturating down-counter timing the macro pin phases
// Revision 1.0
// ============================================================================
`default_nettype none

module efuse_tcnt #(
  parameter int W = 8
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  input  wire logic         load,
  input  wire logic [W-1:0] load_val,
  input  wire logic         en,
  output logic              zero
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/efuse_macro_seq.sv
// ============================================================================
// efuse_macro_seq -- sequences word reads and bit programming on a 32x8 efuse macro
// Revision 1.0
// ============================================================================
`default_nettype none

module efuse_macro_seq
  import efuse_pkg::*;
#(
  parameter int NR    = 64,
  parameter int NW    = 64,
  parameter int T_SU  = 2,
  parameter int T_RD  = 4,
  parameter int T_PGM = 20,
  parameter int T_HLD = 2
) (
  input  wire logic                clk,
  input  wire logic                rst_n,
  efuse_macro_seq_if.slave         bus,
  output logic                     efuse_csb,
  output logic                     efuse_pgenb,
  output logic                     efuse_load,
  output logic                     efuse_strobe,
  output logic [EFUSE_AW-1:0]      efuse_addr,
  input  wire logic [EFUSE_DW-1:0] efuse_dout
);

  localparam int TMAX_A = (T_SU > T_RD) ? T_SU : T_RD;
  localparam int TMAX_B = (T_PGM > T_HLD) ? T_PGM : T_HLD;
  localparam int TMAX   = (TMAX_A > TMAX_B) ? TMAX_A : TMAX_B;
  localparam int TW     = $clog2(TMAX + 1);
  localparam int NWORDS = NR / EFUSE_DW;

  state_t              state_q, state_d;
  logic [EFUSE_AW-1:0] idx_q, idx_d, base_q, base_d, addr_d;
  logic [NW-1:0]       wdata_q, wdata_d;
  logic [NR-1:0]       rdata_q, rdata_d;
  logic                is_rd_q, is_rd_d;
  logic                csb_d, pgenb_d, load_d, strobe_d;
  logic                rdone_q, rdone_d, wdone_q, wdone_d;
  logic                busy_r_q, busy_r_d, busy_w_q, busy_w_d;
  logic                tm_load, tm_zero;
  logic [TW-1:0]       tm_val;
  logic                last_word, last_bit;

  efuse_tcnt #(.W(TW)) u_tcnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tm_load),
    .load_val (tm_val),
    .en       (state_q != IDLE),
    .zero     (tm_zero)
  );

  assign last_word = (idx_q == EFUSE_AW'(NWORDS - 1));
  assign last_bit  = (idx_q == EFUSE_AW'(NW - 1));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    base_d  = base_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    is_rd_d = is_rd_q;
    tm_load = 1'b0;
    tm_val  = '0;

    unique case (state_q)
      IDLE: begin
        if (bus.read_start) begin
          state_d = RD_SU;
          is_rd_d = 1'b1;
          idx_d   = '0;
          base_d  = EFUSE_AW'(bus.read_sel) * EFUSE_AW'(NWORDS);
          tm_load = 1'b1;
          tm_val  = TW'(T_SU - 1);
        end else if (bus.write_start) begin
          state_d = WR_CHK;
          is_rd_d = 1'b0;
          idx_d   = '0;
          base_d  = EFUSE_AW'(bus.write_sel) * EFUSE_AW'(NW);
          wdata_d = bus.write_data;
        end
      end
      RD_SU: if (tm_zero) begin
        state_d = RD_STB;
        tm_load = 1'b1;
        tm_val  = TW'(T_RD - 1);
      end
      RD_STB: if (tm_zero) begin
        for (int k = 0; k < NWORDS; k++) begin
          if (idx_q == EFUSE_AW'(k)) rdata_d[8*k +: 8] = efuse_dout;
        end
        state_d = RD_HLD;
        tm_load = 1'b1;
        tm_val  = TW'(T_HLD - 1);
      end
      RD_HLD: if (tm_zero) begin
        if (last_word) begin
          state_d = DONE;
        end else begin
          state_d = RD_SU;
          idx_d   = idx_q + 1'b1;
          tm_load = 1'b1;
          tm_val  = TW'(T_SU - 1);
        end
      end
      // Pending bits are shifted down so bit 0 is always the one under test.
      WR_CHK: begin
        if (wdata_q[0]) begin
          state_d = WR_SU;
          tm_load = 1'b1;
          tm_val  = TW'(T_SU - 1);
        end else if (last_bit) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          wdata_d = wdata_q >> 1;
        end
      end
      WR_SU: if (tm_zero) begin
        state_d = WR_PGM;
        tm_load = 1'b1;
        tm_val  = TW'(T_PGM - 1);
      end
      WR_PGM: if (tm_zero) begin
        state_d = WR_HLD;
        tm_load = 1'b1;
        tm_val  = TW'(T_HLD - 1);
      end
      WR_HLD: if (tm_zero) begin
        if (last_bit) begin
          state_d = DONE;
        end else begin
          state_d = WR_CHK;
          idx_d   = idx_q + 1'b1;
          wdata_d = wdata_q >> 1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Pins are derived from the next state so they leave the flops aligned with it.
    csb_d    = (state_d == IDLE) || (state_d == DONE);
    load_d   = state_d inside {RD_SU, RD_STB, RD_HLD};
    pgenb_d  = !(state_d inside {WR_SU, WR_PGM, WR_HLD});
    strobe_d = state_d inside {RD_STB, WR_PGM};
    addr_d   = (state_d == RD_SU || state_d == WR_SU) ? (base_d + idx_d) : efuse_addr;
    rdone_d  = (state_d == DONE) && is_rd_d;
    wdone_d  = (state_d == DONE) && !is_rd_d;
    busy_r_d = (state_d != IDLE) && is_rd_d;
    busy_w_d = (state_d != IDLE) && !is_rd_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      base_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      is_rd_q      <= 1'b0;
      efuse_csb    <= 1'b1;
      efuse_pgenb  <= 1'b1;
      efuse_load   <= 1'b0;
      efuse_strobe <= 1'b0;
      efuse_addr   <= '0;
      rdone_q      <= 1'b0;
      wdone_q      <= 1'b0;
      busy_r_q     <= 1'b0;
      busy_w_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      base_q       <= base_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      is_rd_q      <= is_rd_d;
      efuse_csb    <= csb_d;
      efuse_pgenb  <= pgenb_d;
      efuse_load   <= load_d;
      efuse_strobe <= strobe_d;
      efuse_addr   <= addr_d;
      rdone_q      <= rdone_d;
      wdone_q      <= wdone_d;
      busy_r_q     <= busy_r_d;
      busy_w_q     <= busy_w_d;
    end
  end

  assign bus.read_done        = rdone_q;
  assign bus.read_data        = rdata_q;
  assign bus.efuse_busy_read  = busy_r_q;
  assign bus.write_done       = wdone_q;
  assign bus.efuse_busy_write = busy_w_q;

endmodule

`default_nettype wire

// File: tb/tb_efuse_macro_seq.sv
// ============================================================================
// tb_efuse_macro_seq -- directed self-checking bench for efuse_macro_seq
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_efuse_macro_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       efuse_csb, efuse_pgenb, efuse_load, efuse_strobe;
  logic [7:0] efuse_addr;
  logic [7:0] efuse_dout;

  efuse_macro_seq_if #(.NR(64), .NW(64)) bus ();

  efuse_macro_seq dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .efuse_csb    (efuse_csb),
    .efuse_pgenb  (efuse_pgenb),
    .efuse_load   (efuse_load),
    .efuse_strobe (efuse_strobe),
    .efuse_addr   (efuse_addr),
    .efuse_dout   (efuse_dout)
  );

  always #5 clk = ~clk;

  // Macro model: word w reads back as 8'hA0 + w.
  assign efuse_dout = 8'hA0 + efuse_addr;

  int n_pass  = 0;
  int n_total = 0;

  int          rd_done_cyc, rd_done_cnt, wr_done_cyc, wr_done_cnt;
  int          busy_r_cyc, busy_w_cyc, pgenb_low_cyc, stb_pg_low_cyc, n_pulses;
  logic        csb1, load1, pgenb1;
  logic [7:0]  addr1;
  logic [63:0] addr_pack, len_pack;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic run(input bit rd, input bit wr, input logic [1:0] rs, input logic [1:0] ws,
                     input logic [63:0] wd, input int ncyc, input int dup_at);
    logic prev;
    logic [7:0] cur;
    rd_done_cyc = -1; rd_done_cnt = 0; wr_done_cyc = -1; wr_done_cnt = 0;
    busy_r_cyc = 0; busy_w_cyc = 0; pgenb_low_cyc = 0; stb_pg_low_cyc = 0; n_pulses = 0;
    addr_pack = '0; len_pack = '0; prev = 1'b0; cur = '0;
    @(posedge clk); #1;
    bus.read_start  = rd;
    bus.write_start = wr;
    bus.read_sel    = rs;
    bus.write_sel   = ws;
    bus.write_data  = wd;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk); #1;
      bus.read_start  = (c == dup_at);
      bus.write_start = 1'b0;
      if (c == 1) begin
        csb1 = efuse_csb; load1 = efuse_load; pgenb1 = efuse_pgenb; addr1 = efuse_addr;
      end
      if (bus.read_done) begin
        rd_done_cnt++;
        if (rd_done_cyc < 0) rd_done_cyc = c;
      end
      if (bus.write_done) begin
        wr_done_cnt++;
        if (wr_done_cyc < 0) wr_done_cyc = c;
      end
      if (bus.efuse_busy_read)  busy_r_cyc++;
      if (bus.efuse_busy_write) busy_w_cyc++;
      if (!efuse_pgenb) pgenb_low_cyc++;
      if (efuse_strobe && !efuse_pgenb) stb_pg_low_cyc++;
      if (efuse_strobe && !prev) begin
        n_pulses++;
        addr_pack = {addr_pack[55:0], efuse_addr};
        cur = '0;
      end
      if (efuse_strobe) cur++;
      if (!efuse_strobe && prev) len_pack = {len_pack[55:0], cur};
      prev = efuse_strobe;
    end
  endtask

  initial begin
    int seen;
    bus.read_start = 1'b0; bus.write_start = 1'b0;
    bus.read_sel = '0; bus.write_sel = '0; bus.write_data = '0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pins", {efuse_csb, efuse_pgenb, efuse_load, efuse_strobe, efuse_addr}, {4'b1100, 8'h00});
    chk("rst_flags", {bus.read_done, bus.write_done, bus.efuse_busy_read, bus.efuse_busy_write}, 4'b0000);
    chk("rst_rdata", bus.read_data, 64'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_pins", {efuse_csb, efuse_pgenb, efuse_load, efuse_strobe}, 4'b1100);

    // Read sel=1
    run(1'b1, 1'b0, 2'd1, 2'd0, 64'h0, 70, -1);
    chk("rd1_cyc1", {csb1, load1, pgenb1, addr1}, {3'b011, 8'd8});
    chk("rd1_done_cyc", rd_done_cyc, 65);
    chk("rd1_done_cnt", rd_done_cnt, 1);
    chk("rd1_data", bus.read_data, 64'hAFAEADACABAAA9A8);
    chk("rd1_addr_seq", addr_pack, 64'h08090A0B0C0D0E0F);
    chk("rd1_stb_len", len_pack, 64'h0404040404040404);
    chk("rd1_busy_r", busy_r_cyc, 65);
    chk("rd1_no_pgenb", pgenb_low_cyc, 0);
    chk("rd1_idle_pins", {efuse_csb, efuse_load, efuse_strobe}, 3'b100);

    // Write sel=2, data=5
    run(1'b0, 1'b1, 2'd0, 2'd2, 64'h5, 120, -1);
    chk("wr5_cyc1", {csb1, load1, pgenb1}, 3'b001);
    chk("wr5_done_cyc", wr_done_cyc, 113);
    chk("wr5_done_cnt", wr_done_cnt, 1);
    chk("wr5_no_rdone", rd_done_cnt, 0);
    chk("wr5_pulses", n_pulses, 2);
    chk("wr5_addr", addr_pack, 64'h8082);
    chk("wr5_len", len_pack, 64'h1414);
    chk("wr5_stb_pg", stb_pg_low_cyc, 40);
    chk("wr5_pg_low", pgenb_low_cyc, 48);
    chk("wr5_busy_w", busy_w_cyc, 113);
    chk("wr5_rdata_held", bus.read_data, 64'hAFAEADACABAAA9A8);
    chk("wr5_end_pins", {efuse_csb, efuse_pgenb}, 2'b11);

    // Write of all-zero data
    run(1'b0, 1'b1, 2'd0, 2'd1, 64'h0, 70, -1);
    chk("wr0_done_cyc", wr_done_cyc, 65);
    chk("wr0_pulses", n_pulses, 0);
    chk("wr0_pg_low", pgenb_low_cyc, 0);
    chk("wr0_busy_w", busy_w_cyc, 65);

    // Simultaneous read and write: read wins
    run(1'b1, 1'b1, 2'd0, 2'd1, 64'hFFFF_FFFF_FFFF_FFFF, 70, -1);
    chk("both_rd_done", rd_done_cyc, 65);
    chk("both_rdata", bus.read_data, 64'hA7A6A5A4A3A2A1A0);
    chk("both_no_wdone", wr_done_cnt, 0);
    chk("both_busy_w", busy_w_cyc, 0);
    chk("both_pg_low", pgenb_low_cyc, 0);

    // Second read request mid-read is ignored
    run(1'b1, 1'b0, 2'd2, 2'd0, 64'h0, 140, 10);
    chk("dup_done_cyc", rd_done_cyc, 65);
    chk("dup_done_cnt", rd_done_cnt, 1);
    chk("dup_rdata", bus.read_data, 64'hB7B6B5B4B3B2B1B0);

    // Reset asserted during WR_PGM
    @(posedge clk); #1;
    bus.write_start = 1'b1; bus.write_sel = 2'd0; bus.write_data = 64'h1;
    seen = 0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      bus.write_start = 1'b0;
      if (bus.write_done) seen++;
    end
    chk("rstm_in_pgm", {efuse_strobe, efuse_pgenb}, 2'b10);
    rst_n = 1'b0;
    #1;
    chk("rstm_pins", {efuse_strobe, efuse_pgenb, efuse_csb, efuse_load}, 4'b0110);
    repeat (3) @(posedge clk);
    #1;
    chk("rstm_busy", {bus.efuse_busy_write, bus.write_done}, 2'b00);
    rst_n = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (bus.write_done) seen++;
    end
    chk("rstm_no_wdone", seen, 0);
    run(1'b1, 1'b0, 2'd3, 2'd0, 64'h0, 70, -1);
    chk("rstm_rd_done", rd_done_cyc, 65);
    chk("rstm_rdata", bus.read_data, 64'hBFBEBDBCBBBAB9B8);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
